lenet_layer_sequencer: RTL and testbench

//  Sequences the conv->ReLU->maxpool layer over NUM_CH output channels for one input frame.

---
 rtl/lenet_layer_sequencer_if.sv | 31 +++
 rtl/lenet_layer_sequencer.sv | 163 ++++++++++++++++
 tb/tb_lenet_layer_sequencer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/lenet_layer_sequencer_if.sv
// Handshake bundle between the pixel source, the layer sequencer and the layer datapath.
// The slave modport is the sequencer's view; master is the environment driving it.
interface lenet_layer_sequencer_if #(
  parameter int CH_W = 3
);
  logic              frame_start;
  logic              in_valid;
  logic signed [7:0] in_pixel;
  logic              in_ready;
  logic              layer_start;
  logic              layer_valid;
  logic signed [7:0] layer_pixel;
  logic [CH_W-1:0]   weight_sel;
  logic [CH_W-1:0]   ch_idx;
  logic              layer_done_in;
  logic              busy;
  logic              frame_done;
  logic              err;

  modport slave (
    input  frame_start, in_valid, in_pixel, layer_done_in,
    output in_ready, layer_start, layer_valid, layer_pixel,
           weight_sel, ch_idx, busy, frame_done, err
  );

  modport master (
    output frame_start, in_valid, in_pixel, layer_done_in,
    input  in_ready, layer_start, layer_valid, layer_pixel,
           weight_sel, ch_idx, busy, frame_done, err
  );
endinterface

// File: rtl/lenet_layer_sequencer.sv
// Captures one input frame, then replays it once per output channel to the conv/ReLU/pool
// datapath, selecting each weight set in turn and waiting for the datapath's done pulse.
module lenet_layer_sequencer #(
  parameter int MAPSIZE = 32,
  parameter int NUM_CH  = 6,
  parameter int ROW_GAP = 0,
  parameter int TIMEOUT = 4096
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  lenet_layer_sequencer_if.slave bus
);
  localparam int NPIX = MAPSIZE * MAPSIZE;
  localparam int AW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int CW   = (MAPSIZE > 1) ? $clog2(MAPSIZE) : 1;
  localparam int CHW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int GW   = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
  localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [AW-1:0]  LAST_ADDR = AW'(NPIX - 1);
  localparam logic [CW-1:0]  LAST_COL  = CW'(MAPSIZE - 1);
  localparam logic [CHW-1:0] LAST_CH   = CHW'(NUM_CH - 1);
  localparam logic [TW-1:0]  LAST_WAIT = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0]  GAP_LEN   = GW'(ROW_GAP);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_START, S_STREAM, S_WAIT_DONE, S_DONE
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic signed [7:0] r_mem [0:NPIX-1];
  logic signed [7:0] r_rdata;
  logic [AW-1:0]     r_wr_addr;
  logic [AW-1:0]     r_rd_addr;
  logic [CW-1:0]     r_col;
  logic [GW-1:0]     r_gap_cnt;
  logic [TW-1:0]     r_wait_cnt;
  logic [CHW-1:0]    r_ch_idx;
  logic              r_last_issued;
  logic              r_layer_valid;
  logic              r_in_ready;
  logic              r_layer_start;
  logic              r_busy;
  logic              r_frame_done;
  logic              r_err;
  logic              w_accept;
  logic              w_rd_en;
  logic              w_done_hit;
  logic              w_timeout;

  assign w_accept   = (r_state == S_LOAD) && bus.in_valid;
  assign w_rd_en    = (r_state == S_STREAM) && !r_last_issued && (r_gap_cnt == '0);
  assign w_done_hit = (r_state == S_WAIT_DONE) && bus.layer_done_in;
  assign w_timeout  = (r_state == S_WAIT_DONE) && !bus.layer_done_in && (r_wait_cnt == LAST_WAIT);

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.frame_start) w_next = S_LOAD; else w_next = S_IDLE;
      S_LOAD:   if (w_accept && (r_wr_addr == LAST_ADDR)) w_next = S_START; else w_next = S_LOAD;
      S_START:  w_next = S_STREAM;
      // leave only once the final replayed pixel is actually on the output
      S_STREAM: if (r_layer_valid && r_last_issued) w_next = S_WAIT_DONE; else w_next = S_STREAM;
      S_WAIT_DONE: begin
        if (bus.layer_done_in) begin
          if (r_ch_idx == LAST_CH) w_next = S_DONE; else w_next = S_START;
        end else if (w_timeout) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_WAIT_DONE;
        end
      end
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr_addr     <= '0;
      r_rd_addr     <= '0;
      r_col         <= '0;
      r_gap_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_ch_idx      <= '0;
      r_last_issued <= 1'b0;
      r_layer_valid <= 1'b0;
      r_in_ready    <= 1'b0;
      r_layer_start <= 1'b0;
      r_busy        <= 1'b0;
      r_frame_done  <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_in_ready    <= (w_next == S_LOAD);
      r_layer_start <= (w_next == S_START);
      r_busy        <= (w_next != S_IDLE);
      r_frame_done  <= (w_next == S_DONE);
      r_layer_valid <= w_rd_en;

      if ((r_state == S_IDLE) && bus.frame_start) begin
        r_wr_addr <= '0;
        r_ch_idx  <= '0;
        r_err     <= 1'b0;
      end else if (w_accept) begin
        r_wr_addr <= r_wr_addr + AW'(1);
      end else if (w_done_hit && (r_ch_idx != LAST_CH)) begin
        r_ch_idx <= r_ch_idx + CHW'(1);
      end else if (w_timeout) begin
        r_err <= 1'b1;
      end

      if (w_next == S_START) begin
        r_rd_addr     <= '0;
        r_col         <= '0;
        r_gap_cnt     <= '0;
        r_last_issued <= 1'b0;
      end else if (w_rd_en) begin
        r_rd_addr <= r_rd_addr + AW'(1);
        if (r_col == LAST_COL) begin
          r_col     <= '0;
          r_gap_cnt <= (r_rd_addr == LAST_ADDR) ? '0 : GAP_LEN;
        end else begin
          r_col <= r_col + CW'(1);
        end
        if (r_rd_addr == LAST_ADDR) r_last_issued <= 1'b1;
      end else if (r_gap_cnt != '0) begin
        r_gap_cnt <= r_gap_cnt - GW'(1);
      end

      if (r_state == S_WAIT_DONE) r_wait_cnt <= r_wait_cnt + TW'(1);
      else                        r_wait_cnt <= '0;
    end
  end

  // frame buffer write port; contents are deliberately not reset
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wr_addr] <= bus.in_pixel;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst)       r_rdata <= '0;
    else if (w_rd_en) r_rdata <= r_mem[r_rd_addr];
  end

  assign bus.in_ready    = r_in_ready;
  assign bus.layer_start = r_layer_start;
  assign bus.layer_valid = r_layer_valid;
  assign bus.layer_pixel = r_rdata;
  assign bus.weight_sel  = r_ch_idx;
  assign bus.ch_idx      = r_ch_idx;
  assign bus.busy        = r_busy;
  assign bus.frame_done  = r_frame_done;
  assign bus.err         = r_err;
endmodule

// File: tb/tb_lenet_layer_sequencer.sv
// Directed bench: 4x4 frames, two channels; dut_a has no row gap and TIMEOUT=8, dut_b has ROW_GAP=2.
module tb_lenet_layer_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lenet_layer_sequencer_if #(.CH_W(1)) bus_a ();
  lenet_layer_sequencer_if #(.CH_W(1)) bus_b ();

  lenet_layer_sequencer #(.MAPSIZE(4), .NUM_CH(2), .ROW_GAP(0), .TIMEOUT(8)) dut_a (
    .i_clk(clk), .i_rst(rst), .bus(bus_a.slave)
  );
  lenet_layer_sequencer #(.MAPSIZE(4), .NUM_CH(2), .ROW_GAP(2), .TIMEOUT(8)) dut_b (
    .i_clk(clk), .i_rst(rst), .bus(bus_b.slave)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_a();
    bus_a.frame_start = 1'b1;
    tick();
    bus_a.frame_start = 1'b0;
    chk("load_ready", bus_a.in_ready, 1);
    chk("load_busy", bus_a.busy, 1);
  endtask

  // toggle inserts an idle beat before each pixel; extra leaves a 17th beat asserted
  task automatic load_a(input bit toggle, input bit extra);
    for (int i = 0; i < 16; i++) begin
      if (toggle) begin
        bus_a.in_valid = 1'b0;
        bus_a.in_pixel = 8'sd77;
        tick();
        chk("load_gap_ready", bus_a.in_ready, 1);
      end
      bus_a.in_valid = 1'b1;
      bus_a.in_pixel = 8'(i);
      tick();
    end
    chk("ready_drop", bus_a.in_ready, 0);
    if (extra) bus_a.in_pixel = 8'sd99;
    else       bus_a.in_valid = 1'b0;
  endtask

  // mode: 0 normal, 1 spurious inputs in STREAM, 2 no done (timeout), 3 reset mid-stream
  task automatic chan_a(input int ch, input int mode);
    chk("start_pulse", bus_a.layer_start, 1);
    chk("weight_sel", bus_a.weight_sel, ch);
    chk("ch_idx", bus_a.ch_idx, ch);
    tick();
    bus_a.in_valid = 1'b0;
    chk("start_one_cycle", bus_a.layer_start, 0);
    chk("valid_latency", bus_a.layer_valid, 0);
    if (mode == 1) begin
      bus_a.frame_start   = 1'b1;
      bus_a.layer_done_in = 1'b1;
    end
    tick();
    bus_a.frame_start   = 1'b0;
    bus_a.layer_done_in = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("replay_valid", bus_a.layer_valid, 1);
      chk("replay_pixel", bus_a.layer_pixel, i);
      if (mode == 3 && i == 3) begin
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("abort_busy", bus_a.busy, 0);
        chk("abort_valid", bus_a.layer_valid, 0);
        chk("abort_ch", bus_a.ch_idx, 0);
        chk("abort_fdone", bus_a.frame_done, 0);
        return;
      end
      tick();
    end
    chk("stream_end_valid", bus_a.layer_valid, 0);
    chk("pixel_hold", bus_a.layer_pixel, 15);
    chk("wait_busy", bus_a.busy, 1);
    if (mode == 2) begin
      repeat (7) tick();
      chk("pre_timeout_err", bus_a.err, 0);
      chk("pre_timeout_busy", bus_a.busy, 1);
      tick();
      chk("timeout_err", bus_a.err, 1);
      chk("timeout_idle", bus_a.busy, 0);
      chk("timeout_no_fdone", bus_a.frame_done, 0);
      tick();
      chk("err_sticky", bus_a.err, 1);
      bus_a.frame_start = 1'b1;
      tick();
      bus_a.frame_start = 1'b0;
      chk("err_cleared", bus_a.err, 0);
      chk("reload_ready", bus_a.in_ready, 1);
      return;
    end
    repeat (4) tick();
    bus_a.layer_done_in = 1'b1;
    tick();
    bus_a.layer_done_in = 1'b0;
    if (ch == 0) begin
      chk("next_start", bus_a.layer_start, 1);
      chk("no_early_fdone", bus_a.frame_done, 0);
    end else begin
      chk("frame_done", bus_a.frame_done, 1);
      chk("done_busy", bus_a.busy, 1);
      tick();
      chk("frame_done_pulse", bus_a.frame_done, 0);
      chk("idle_busy", bus_a.busy, 0);
      chk("idle_err", bus_a.err, 0);
    end
  endtask

  initial begin
    bus_a.frame_start = 1'b0; bus_a.in_valid = 1'b0; bus_a.in_pixel = 8'sd0; bus_a.layer_done_in = 1'b0;
    bus_b.frame_start = 1'b0; bus_b.in_valid = 1'b0; bus_b.in_pixel = 8'sd0; bus_b.layer_done_in = 1'b0;

    // reset state
    repeat (2) tick();
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_ready", bus_a.in_ready, 0);
    chk("rst_valid", bus_a.layer_valid, 0);
    chk("rst_start", bus_a.layer_start, 0);
    chk("rst_fdone", bus_a.frame_done, 0);
    chk("rst_err", bus_a.err, 0);
    chk("rst_ch", bus_a.ch_idx, 0);
    chk("rst_b_busy", bus_b.busy, 0);
    rst = 1'b1;
    tick();
    chk("idle_ready", bus_a.in_ready, 0);

    // plain frame: two channels, one frame_done
    start_a();
    load_a(1'b0, 1'b0);
    chan_a(0, 0);
    chan_a(1, 0);

    // toggled in_valid, a 17th beat, spurious frame_start/done during replay
    start_a();
    load_a(1'b1, 1'b1);
    chan_a(0, 1);
    chan_a(1, 1);

    // row gap of 2 on dut_b
    bus_b.frame_start = 1'b1;
    tick();
    bus_b.frame_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      bus_b.in_valid = 1'b1;
      bus_b.in_pixel = 8'(i);
      tick();
    end
    bus_b.in_valid = 1'b0;
    chk("b_start", bus_b.layer_start, 1);
    repeat (2) tick();
    for (int c = 0; c < 22; c++) begin
      chk("b_valid", bus_b.layer_valid, ((c % 6) < 4) ? 1 : 0);
      if ((c % 6) < 4) chk("b_pixel", bus_b.layer_pixel, (c / 6) * 4 + (c % 6));
      tick();
    end
    chk("b_after_last", bus_b.layer_valid, 0);

    // timeout in WAIT_DONE, then reset during channel 1 replay
    start_a();
    load_a(1'b0, 1'b0);
    chan_a(0, 2);
    load_a(1'b0, 1'b0);
    chan_a(0, 0);
    chan_a(1, 3);

    // fresh frame after the abort
    tick();
    start_a();
    load_a(1'b0, 1'b0);
    chan_a(0, 0);
    chan_a(1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
